// File: rtl/key_code_fifo.sv
// key_code_fifo
//   Decodes PS/2 scan codes into 5-bit key codes and queues them in a
//   first-word-fall-through FIFO for a downstream consumer.
//
//   Pipeline: stage 1 registers the decoded code plus a one-cycle valid bit;
//   stage 2 writes that code into the FIFO storage.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   dato[7:0]  scan code from the PS/2 receiver (break codes already removed)
//   tick       one-cycle strobe qualifying dato/correct
//   correct    frame integrity flag, sampled with tick
//   rd_en      consumer pop request (ignored while empty)
//   clr_flags  clears overflow and err_cnt
//   key[4:0]   key code at FIFO head, 0 when empty
//   empty      FIFO holds no entries
//   full       FIFO holds DEPTH entries
//   count[4:0] number of entries held
//   overflow   sticky: a valid key was dropped because the FIFO was full
//   err_cnt    saturating count of rejected ticks
module key_code_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dato,
    input  logic       tick,
    input  logic       correct,
    input  logic       rd_en,
    input  logic       clr_flags,
    output logic [4:0] key,
    output logic       empty,
    output logic       full,
    output logic [4:0] count,
    output logic       overflow,
    output logic [3:0] err_cnt
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

    // Returns {hit, code}; hit=0 for scan codes outside the key map.
    function automatic logic [5:0] decode_scan(input logic [7:0] scan);
        case (scan)
            8'h45: return {1'b1, 5'd0};
            8'h16: return {1'b1, 5'd1};
            8'h1E: return {1'b1, 5'd2};
            8'h26: return {1'b1, 5'd3};
            8'h25: return {1'b1, 5'd4};
            8'h2E: return {1'b1, 5'd5};
            8'h36: return {1'b1, 5'd6};
            8'h3D: return {1'b1, 5'd7};
            8'h3E: return {1'b1, 5'd8};
            8'h46: return {1'b1, 5'd9};
            8'h1C: return {1'b1, 5'd10};
            8'h32: return {1'b1, 5'd11};
            8'h21: return {1'b1, 5'd12};
            8'h23: return {1'b1, 5'd13};
            8'h24: return {1'b1, 5'd14};
            8'h2B: return {1'b1, 5'd15};
            8'h5A: return {1'b1, 5'd16};
            8'h66: return {1'b1, 5'd17};
            8'h76: return {1'b1, 5'd18};
            default: return 6'd0;
        endcase
    endfunction

    // Saturating increment; the error counter must stick at 15.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic [5:0]    dec;
    logic          accept;
    logic [4:0]    code_p0;
    logic          vld_p0;
    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push_ok;
    logic          drop;

    assign dec    = decode_scan(dato);
    assign accept = tick && correct && dec[5];

    // ---- stage 1 (_p0): registered decode --------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            code_p0 <= dec[4:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_flags) begin
            err_cnt <= 4'd0;
        end else if (tick && !accept) begin
            err_cnt <= sat_inc4(err_cnt);
        end
    end

    // ---- stage 2: FIFO write / read ----------------------------------------
    // A pop frees the slot this same edge, so a push while full still lands.
    assign pop     = rd_en && !empty;
    assign push_ok = vld_p0 && (!full || pop);
    assign drop    = vld_p0 && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= code_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_flags) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    assign empty = (count == 5'd0);
    assign full  = (count == DEPTH_CNT);
    assign key   = empty ? 5'd0 : mem[rd_ptr];

endmodule

// File: tb/tb_key_code_fifo.sv
module tb_key_code_fifo;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dato = 8'd0;
    logic       tick = 1'b0;
    logic       correct = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_flags = 1'b0;
    logic [4:0] key;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic [3:0] err_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    int mq[$];
    bit m_pend = 0;
    int m_pcode = 0;
    bit m_ovf = 0;
    int m_err = 0;

    logic [7:0] scan_tab [19] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                  8'h3D, 8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23,
                                  8'h24, 8'h2B, 8'h5A, 8'h66, 8'h76};

    key_code_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .dato(dato), .tick(tick), .correct(correct),
        .rd_en(rd_en), .clr_flags(clr_flags), .key(key), .empty(empty),
        .full(full), .count(count), .overflow(overflow), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lookup(input logic [7:0] d);
        for (int i = 0; i < 19; i++) if (scan_tab[i] == d) return i;
        return -1;
    endfunction

    // Drive one clock cycle of inputs and advance the model by one edge.
    task automatic drive(input bit t, input logic [7:0] d, input bit c,
                         input bit r, input bit cl, input bit rs);
        int idx;
        bit pop_ok;
        tick = t; dato = d; correct = c; rd_en = r; clr_flags = cl; rst = rs;
        idx = lookup(d);
        if (rs) begin
            mq.delete(); m_pend = 0; m_ovf = 0; m_err = 0;
        end else begin
            pop_ok = r && (mq.size() > 0);
            if (pop_ok) void'(mq.pop_front());
            if (m_pend) begin
                if (mq.size() < DEPTH) mq.push_back(m_pcode);
                else m_ovf = 1;
            end
            if (t && !(c && idx >= 0) && m_err < 15) m_err++;
            if (cl) begin m_ovf = 0; m_err = 0; end
            m_pend = t && c && (idx >= 0);
            m_pcode = (idx >= 0) ? idx : 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(0, 8'h00, 0, 0, 0, 1);
        drive(1, 8'h45, 1, 1, 1, 1);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %0d want 1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %0d want 0", full); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (key !== 5'd0) begin bad++; $display("FAIL reset_key: got %0d want 0", key); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %0d want 0", overflow); end
        total++; if (err_cnt !== 4'd0) begin bad++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
        drive(0, 8'h00, 0, 0, 0, 0);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_no_push: empty=%0d want 1", empty); end
    endtask

    task automatic test_single_key();
        drive(1, 8'h16, 1, 0, 0, 0);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_latency: empty=%0d want 1 after 1 edge", empty); end
        idle();
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_empty: got %0d want 0", empty); end
        total++; if (key !== 5'd1) begin bad++; $display("FAIL single_key: got %0d want 1", key); end
        total++; if (count !== 5'd1) begin bad++; $display("FAIL single_count: got %0d want 1", count); end
        drive(0, 8'h00, 0, 1, 0, 0);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_pop_empty: got %0d want 1", empty); end
        total++; if (key !== 5'd0) begin bad++; $display("FAIL single_pop_key: got %0d want 0", key); end
    endtask

    task automatic test_order_wrap();
        for (int i = 0; i < 8; i++) drive(1, scan_tab[i], 1, 0, 0, 0);
        idle();
        total++; if (count !== 5'd8) begin bad++; $display("FAIL wrap_count8: got %0d want 8", count); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL wrap_full: got %0d want 1", full); end
        for (int i = 0; i < 3; i++) begin
            total++; if (key !== 5'(i)) begin bad++; $display("FAIL wrap_pop_a: got %0d want %0d", key, i); end
            drive(0, 8'h00, 0, 1, 0, 0);
        end
        for (int i = 8; i < 11; i++) drive(1, scan_tab[i], 1, 0, 0, 0);
        idle();
        total++; if (count !== 5'd8) begin bad++; $display("FAIL wrap_refill: got %0d want 8", count); end
        for (int i = 3; i < 11; i++) begin
            total++; if (key !== 5'(i)) begin bad++; $display("FAIL wrap_pop_b: got %0d want %0d", key, i); end
            drive(0, 8'h00, 0, 1, 0, 0);
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_drained: empty=%0d want 1", empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) drive(1, scan_tab[i], 1, 0, 0, 0);
        idle();
        drive(1, 8'h5A, 1, 0, 0, 0);
        idle();
        total++; if (count !== 5'd8) begin bad++; $display("FAIL ovf_count: got %0d want 8", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %0d want 1", overflow); end
        total++; if (key !== 5'd0) begin bad++; $display("FAIL ovf_head: got %0d want 0", key); end
        drive(1, 8'h66, 1, 0, 0, 0);
        drive(0, 8'h00, 0, 1, 0, 0);
        total++; if (count !== 5'd8) begin bad++; $display("FAIL ovf_pushpop_count: got %0d want 8", count); end
        total++; if (key !== 5'd1) begin bad++; $display("FAIL ovf_pushpop_head: got %0d want 1", key); end
        drive(0, 8'h00, 0, 0, 1, 0);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %0d want 0", overflow); end
        total++; if (count !== 5'd8) begin bad++; $display("FAIL ovf_clear_count: got %0d want 8", count); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (key !== ((i < 7) ? 5'(i + 1) : 5'd17)) begin
                bad++; $display("FAIL ovf_drain: got %0d at pop %0d", key, i);
            end
            drive(0, 8'h00, 0, 1, 0, 0);
        end
    endtask

    task automatic test_rejects();
        for (int i = 0; i < 3; i++) begin
            drive(1, scan_tab[i], 0, 0, 0, 0);
            total++; if (empty !== 1'b1) begin bad++; $display("FAIL rej_bad_frame: empty=%0d want 1", empty); end
        end
        for (int i = 0; i < 17; i++) begin
            drive(1, 8'h99, 1, 0, 0, 0);
            total++; if (empty !== 1'b1) begin bad++; $display("FAIL rej_unmapped: empty=%0d want 1", empty); end
        end
        idle();
        total++; if (err_cnt !== 4'd15) begin bad++; $display("FAIL rej_sat: got %0d want 15", err_cnt); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rej_empty: got %0d want 1", empty); end
        drive(1, 8'h99, 1, 0, 1, 0);
        total++; if (err_cnt !== 4'd0) begin bad++; $display("FAIL rej_clr_priority: got %0d want 0", err_cnt); end
    endtask

    task automatic test_reset_mid();
        drive(1, 8'h76, 1, 0, 0, 0);
        drive(0, 8'h00, 0, 0, 0, 1);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rstmid_empty: got %0d want 1", empty); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", count); end
        for (int i = 0; i < 3; i++) begin
            idle();
            total++; if (empty !== 1'b1) begin bad++; $display("FAIL rstmid_ghost: empty=%0d want 1", empty); end
        end
    endtask

    task automatic test_pop_empty();
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'h00, 0, 1, 0, 0);
            total++; if (count !== 5'd0) begin bad++; $display("FAIL popempty_count: got %0d want 0", count); end
        end
        drive(1, 8'h2E, 1, 0, 0, 0);
        drive(1, 8'h1C, 1, 1, 0, 0);
        idle();
        total++; if (key !== 5'd5) begin bad++; $display("FAIL popempty_head: got %0d want 5", key); end
        total++; if (count !== 5'd2) begin bad++; $display("FAIL popempty_after: got %0d want 2", count); end
        drive(0, 8'h00, 0, 1, 0, 0);
        total++; if (key !== 5'd10) begin bad++; $display("FAIL popempty_second: got %0d want 10", key); end
        drive(0, 8'h00, 0, 1, 0, 0);
    endtask

    task automatic test_random();
        int exp_key;
        for (int n = 0; n < 800; n++) begin
            bit t, c, r, cl, rs;
            logic [7:0] d;
            t  = ($urandom_range(0, 99) < 60);
            d  = ($urandom_range(0, 99) < 85) ? scan_tab[$urandom_range(0, 18)] : 8'($urandom);
            c  = ($urandom_range(0, 99) < 90);
            r  = ($urandom_range(0, 99) < ((n % 200 < 100) ? 20 : 60));
            cl = ($urandom_range(0, 99) < 3);
            rs = ($urandom_range(0, 999) < 5);
            drive(t, d, c, r, cl, rs);
            exp_key = (mq.size() > 0) ? mq[0] : 0;
            total++; if (count !== 5'(mq.size())) begin bad++; $display("FAIL rnd_count: got %0d want %0d cyc %0d", count, mq.size(), n); end
            total++; if (key !== 5'(exp_key)) begin bad++; $display("FAIL rnd_key: got %0d want %0d cyc %0d", key, exp_key, n); end
            total++; if (empty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_empty: got %0d cyc %0d", empty, n); end
            total++; if (full !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rnd_full: got %0d cyc %0d", full, n); end
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf: got %0d want %0d cyc %0d", overflow, m_ovf, n); end
            total++; if (err_cnt !== 4'(m_err)) begin bad++; $display("FAIL rnd_err: got %0d want %0d cyc %0d", err_cnt, m_err, n); end
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_order_wrap();
        test_overflow();
        test_rejects();
        test_reset_mid();
        test_pop_empty();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_code_fifo.md
KEY_CODE_FIFO -- requirements
Module: key_code_fifo

Interface
REQ-001 Parameter: DEPTH, default 8, number of FIFO entries; power of two, 4..16.
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: dato  input  8  scan code from the upstream PS/2 receiver (break codes already filtered).
REQ-005 Port: tick  input  1  one-cycle strobe; dato is valid in the same cycle.
REQ-006 Port: correct  input  1  frame integrity flag; sampled with tick.
REQ-007 Port: rd_en  input  1  consumer pop request.
REQ-008 Port: clr_flags  input  1  clears overflow and err_cnt.
REQ-009 Port: key  output  5  decoded key code at FIFO head.
REQ-010 Port: empty  output  1  FIFO holds no entries.
REQ-011 Port: full  output  1  FIFO holds DEPTH entries.
REQ-012 Port: count  output  5  number of entries held, 0..DEPTH.
REQ-013 Port: overflow  output  1  sticky flag: a valid key was dropped because the FIFO was full.
REQ-014 Port: err_cnt  output  4  saturating count of rejected ticks.

Function
REQ-015 Decode map for key (hex scan -> code):
- digits 45,16,1E,26,25,2E,36,3D,3E,46 -> 0..9
- letters 1C,32,21,23,24,2B -> 10..15 (A..F)
- 5A Enter -> 16; 66 Backspace -> 17; 76 Esc -> 18
REQ-016 Stage 1 is a registered decode: on an edge with tick=1, latch the decoded code and a valid bit; the valid bit is high for exactly one cycle.
REQ-017 A tick with correct=0 SHALL NOT set the valid bit and SHALL increment err_cnt.
REQ-018 A tick with correct=1 and a scan code outside the map SHALL NOT set the valid bit and SHALL increment err_cnt.
REQ-019 err_cnt SHALL saturate at 15 and not wrap.
REQ-020 Stage 2: on the edge after stage-1 valid, write the code at the write pointer unless the push is blocked (REQ-024).
- tick-to-empty-deassert latency: 2 clock edges.
REQ-021 The FIFO SHALL be first-word-fall-through: when empty=0, key SHALL show the head entry combinationally from storage.
REQ-022 rd_en=1 with empty=0 SHALL advance the read pointer on the edge; rd_en with empty=1 SHALL be ignored.
REQ-023 Pointers SHALL wrap modulo DEPTH; count SHALL equal pushes minus pops.
REQ-024 A push while full with no pop in the same cycle SHALL be dropped and SHALL set overflow.
REQ-025 A push and a pop in the same cycle SHALL both take effect, including when full; count SHALL be unchanged and overflow SHALL NOT be set.
REQ-026 A push and a pop in the same cycle while empty SHALL perform the push only.
REQ-027 clr_flags=1 SHALL clear overflow and err_cnt on the edge, taking priority over a same-cycle set or increment; FIFO contents SHALL be unaffected.
REQ-028 key SHALL read 0 when empty=1.
REQ-029 Back-to-back ticks on consecutive cycles SHALL each be processed; no input is lost while the FIFO is not full.

Reset
REQ-030 rst=1 SHALL, on the edge:
- clear both pointers, count, the stage-1 valid bit, overflow and err_cnt;
- drive empty=1, full=0, key=0.
REQ-031 rst SHALL take priority over tick, rd_en and clr_flags in the same cycle.
REQ-032 A code held in stage 1 when rst asserts SHALL be discarded.
REQ-033 Storage contents need not be cleared.

Verification
REQ-034 Single key: tick with dato=16, correct=1 -> two edges later empty=0, key=1, count=1; rd_en for 1 cycle -> empty=1, key=0.
REQ-035 Order and wrap: push codes 45,16,1E,26,25,2E,36,3D, then pop 3, then push 3E,46,1C -> pops return 0,1,2, then 3..9, then 10, in order; full=1 at count=8.
REQ-036 Overflow: fill to 8, push 5A with no rd_en -> count=8, overflow=1, head unchanged; then push 66 with rd_en=1 in the same cycle -> count=8, 66 becomes the tail; clr_flags -> overflow=0.
REQ-037 Rejects: 3 ticks with correct=0, then 17 ticks with dato=0x99 -> err_cnt=15 (saturated), empty=1 throughout.
REQ-038 Reset mid-operation: tick with dato=76, rst on the next edge -> empty=1, count=0, no entry appears afterwards.
REQ-039 Pop on empty: rd_en held for 5 cycles with empty=1 -> count stays 0, pointers unchanged; next push reads back correctly.
